window_line_buffer: RTL and testbench
=====================================

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640: pixels per row; legal range >= 3.
REQ-003 SHALL have parameter IMG_H, default 480: rows per frame; legal range >= 3.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Enable, input, 1 bit: DataIn is accepted on any rising CLK where Enable=1 and Reset=0.
REQ-007 SHALL have port DataIn, input, DATA_W bits: raster-order pixel stream, row-major, top-left first.
REQ-008 SHALL have port Window, output, 9*DATA_W bits: 3x3 neighbourhood; tap k=3*i+j at Window[DATA_W*k +: DATA_W]; i = row (0 = oldest), j = column (0 = leftmost).
REQ-009 SHALL have port WindowValid, output, 1 bit: Window holds a complete in-frame 3x3 neighbourhood.
REQ-010 SHALL have port FrameDone, output, 1 bit: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), each $clog2-sized; these give the position of the next pixel to be accepted.
REQ-012 On accept, col SHALL increment; at IMG_W-1, col SHALL wrap to 0 and row SHALL increment; at (IMG_H-1, IMG_W-1), both SHALL wrap to 0.
REQ-013 SHALL implement two line buffers of IMG_W entries each, so that on accepting pixel P(r,c), pixels P(r-1,c) and P(r-2,c) are available in the same cycle.
REQ-014 On accepting P(r,c), the three Window columns SHALL shift left, and new column j=2 SHALL load {P(r-2,c), P(r-1,c), P(r,c)} for i=0,1,2.
REQ-015 Window SHALL then equal P(r-2+i, c-2+j) for all i,j; latency is one CLK from acceptance to the Window update.
REQ-016 WindowValid SHALL be registered high in the cycle after accepting P(r,c) with r>=2 and c>=2, and SHALL be 0 in every other cycle.
REQ-017 Enable=0 SHALL hold the window, line buffers and counters unchanged and SHALL force WindowValid=0 in the next cycle (stall, no data loss).
REQ-018 Window contents while WindowValid=0 (row seams, first two rows of a frame) are don't-care; no consumer may use them.
REQ-019 FrameDone SHALL be 1 in exactly the cycle after accepting P(IMG_H-1, IMG_W-1), and 0 otherwise; it coincides with the final WindowValid of the frame.
REQ-020 Each frame SHALL yield exactly (IMG_H-2)*(IMG_W-2) WindowValid cycles; back-to-back frames SHALL need no idle cycle.
REQ-021 A second frame's windows SHALL never contain first-frame pixels when WindowValid=1.
REQ-022 Line buffers SHALL be synthesisable as RAM or shift registers; the cost of one read and one write per accepted pixel at the same address is part of REQ-013.

Reset
REQ-023 When Reset=1 at a rising CLK: col=0, row=0, WindowValid=0, FrameDone=0, Window=0; Reset SHALL take priority over Enable.
REQ-024 Line-buffer contents need not be cleared; REQ-016 gating alone SHALL guarantee correctness after reset.
REQ-025 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is treated as P(0,0).

Verification (DATA_W=8, IMG_W=5, IMG_H=4, pixel value = 10*r+c)
REQ-026 Continuous Enable, one frame -> first WindowValid one cycle after the 13th accepted pixel, with Window taps k=0..8 = {0,1,2,10,11,12,20,21,22}; 6 valid windows in total, the last = {12,13,14,22,23,24,32,33,34} with FrameDone=1 in the same cycle.
REQ-027 Enable=0 for 3 cycles after P(2,3) -> WindowValid=0 and Window held at {1,2,3,11,12,13,21,22,23} during the stall; after resume, P(2,4) yields {2,3,4,12,13,14,22,23,24}.
REQ-028 Reset pulsed after 7 accepted pixels, then a full frame restreamed -> outputs 0 the cycle after reset, and first WindowValid after 13 more accepts with {0,1,2,10,11,12,20,21,22}.
REQ-029 Two frames back-to-back, frame 2 values +100 -> frame 2's first valid window = {100,101,102,110,111,112,120,121,122}; no frame 1 values appear; 12 valid windows and 2 FrameDone pulses in total.
REQ-030 Reset and Enable both high -> reset wins; counters stay at 0 and the pixel is not accepted.

Source files
------------

// File: rtl/window_line_buffer_if.sv
// window_line_buffer_if
//   Groups the pixel stream and the 3x3 window output of window_line_buffer.
//   Enable      : pixel on DataIn is accepted on this rising clock edge
//   DataIn      : raster-order pixel, row-major, top-left first
//   Window      : 3x3 neighbourhood, tap k=3*i+j at Window[DATA_W*k +: DATA_W]
//                 (i = row, 0 = oldest; j = column, 0 = leftmost)
//   WindowValid : Window holds a complete in-frame neighbourhood
//   FrameDone   : one-cycle pulse after the last pixel of a frame
//   master = pixel source / window consumer, slave = the line buffer itself.
interface window_line_buffer_if #(
    parameter int DATA_W = 8
);
    logic                  Enable;
    logic [DATA_W-1:0]     DataIn;
    logic [9*DATA_W-1:0]   Window;
    logic                  WindowValid;
    logic                  FrameDone;

    modport master (
        output Enable,
        output DataIn,
        input  Window,
        input  WindowValid,
        input  FrameDone
    );

    modport slave (
        input  Enable,
        input  DataIn,
        output Window,
        output WindowValid,
        output FrameDone
    );
endinterface

// File: rtl/window_line_buffer.sv
// window_line_buffer
//   Turns a raster pixel stream into a sliding 3x3 neighbourhood using two
//   single-row line buffers. The window updates one clock after a pixel is
//   accepted; WindowValid marks the cycles where all nine taps are in-frame.
//   Ports:
//     CLK   : single clock, all state changes on the rising edge
//     Reset : synchronous, active-high; clears counters, flags and window
//     bus   : window_line_buffer_if.slave (Enable, DataIn, Window,
//             WindowValid, FrameDone)
module window_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                  CLK,
    input  logic                  Reset,
    window_line_buffer_if.slave   bus
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    // lineBufNear holds row r-1, lineBufFar holds row r-2, indexed by column.
    logic [DATA_W-1:0] lineBufNear [IMG_W];
    logic [DATA_W-1:0] lineBufFar  [IMG_W];

    logic              accept_p0;
    logic [DATA_W-1:0] above1_p0;
    logic [DATA_W-1:0] above2_p0;

    logic [DATA_W-1:0] tap_p1 [9];
    logic              valid_p1;
    logic              done_p1;

    // ---- stage p0: accept decision and line-buffer read ----
    assign accept_p0 = bus.Enable && !Reset;
    assign above1_p0 = lineBufNear[col];
    assign above2_p0 = lineBufFar[col];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            col <= '0;
            row <= '0;
        end else if (accept_p0) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Read-before-write at the same address: the old r-1 pixel moves to the
    // far buffer while the current pixel takes its slot in the near buffer.
    // Contents are never cleared; WindowValid gating hides stale data.
    always_ff @(posedge CLK) begin
        if (accept_p0) begin
            lineBufFar[col]  <= above1_p0;
            lineBufNear[col] <= bus.DataIn;
        end
    end

    // ---- stage p1: window shift and status flags ----
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int k = 0; k < 9; k++) begin
                tap_p1[k] <= '0;
            end
        end else if (accept_p0) begin
            for (int i = 0; i < 3; i++) begin
                tap_p1[3*i]     <= tap_p1[3*i + 1];
                tap_p1[3*i + 1] <= tap_p1[3*i + 2];
            end
            tap_p1[2] <= above2_p0;
            tap_p1[5] <= above1_p0;
            tap_p1[8] <= bus.DataIn;
        end
    end

    // Requiring col>=2 and row>=2 keeps row seams and the previous frame out
    // of any window flagged valid.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_p1 <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            valid_p1 <= accept_p0 && (row >= ROW_TWO) && (col >= COL_TWO);
            done_p1  <= accept_p0 && (row == ROW_LAST) && (col == COL_LAST);
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign bus.Window[DATA_W*k +: DATA_W] = tap_p1[k];
    end

    assign bus.WindowValid = valid_p1;
    assign bus.FrameDone   = done_p1;
endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  din;
        logic        expValid;
        logic        expDone;
        logic        chkWin;
        logic [71:0] expWin;
    } vec_t;

    logic CLK = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    int   validCnt;
    int   doneCnt;
    vec_t vecs[$];

    window_line_buffer_if #(.DATA_W(DATA_W)) bus ();

    window_line_buffer #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] lit(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
        logic [71:0] w;
        w[7:0]   = 8'(t0); w[15:8]  = 8'(t1); w[23:16] = 8'(t2);
        w[31:24] = 8'(t3); w[39:32] = 8'(t4); w[47:40] = 8'(t5);
        w[55:48] = 8'(t6); w[63:56] = 8'(t7); w[71:64] = 8'(t8);
        return w;
    endfunction

    // Expected neighbourhood after accepting P(r,c): tap(i,j) = P(r-2+i, c-2+j).
    function automatic logic [71:0] model(input int r, input int c, input int base);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = 8'(base + 10*(r-2+i) + (c-2+j));
        return w;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [7:0] d);
        Reset      = rst;
        bus.Enable = en;
        bus.DataIn = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic pix(input int r, input int c, input int base);
        step(1'b0, 1'b1, 8'(base + 10*r + c));
    endtask

    task automatic addVec(input logic rst, en, input logic [7:0] d,
                          input logic v, dn, cw, input logic [71:0] w);
        vec_t x;
        x.rst = rst; x.en = en; x.din = d;
        x.expValid = v; x.expDone = dn; x.chkWin = cw; x.expWin = w;
        vecs.push_back(x);
    endtask

    task automatic addFrame(input int base);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                logic v;
                v = (r >= 2) && (c >= 2);
                addVec(1'b0, 1'b1, 8'(base + 10*r + c), v,
                       (r == IMG_H-1) && (c == IMG_W-1), v, model(r, c, base));
            end
    endtask

    initial begin
        Reset      = 1'b1;
        bus.Enable = 1'b0;
        bus.DataIn = '0;

        // Table: reset, then two back-to-back frames (second offset by 100).
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, '0);
        addVec(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, '0);
        addFrame(0);
        addFrame(100);

        validCnt = 0;
        doneCnt  = 0;
        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].en, vecs[n].din);
            if (bus.WindowValid) validCnt++;
            if (bus.FrameDone)   doneCnt++;
            chk("tbl_valid", {71'd0, bus.WindowValid}, {71'd0, vecs[n].expValid});
            chk("tbl_done",  {71'd0, bus.FrameDone},   {71'd0, vecs[n].expDone});
            if (vecs[n].chkWin) chk("tbl_window", bus.Window, vecs[n].expWin);
        end
        chk("b2b_valid_count", 72'(validCnt), 72'd12);
        chk("b2b_done_count",  72'(doneCnt),  72'd2);

        // Single frame with literal first/last windows.
        step(1'b1, 1'b0, 8'h00);
        validCnt = 0;
        for (int p = 0; p < IMG_W*IMG_H; p++) begin
            pix(p / IMG_W, p % IMG_W, 0);
            if (bus.WindowValid) validCnt++;
            if (p == 11) chk("first_valid_early", {71'd0, bus.WindowValid}, 72'd0);
            if (p == 12) begin
                chk("first_valid", {71'd0, bus.WindowValid}, 72'd1);
                chk("first_window", bus.Window, lit(0, 1, 2, 10, 11, 12, 20, 21, 22));
            end
            if (p == 19) begin
                chk("last_window", bus.Window, lit(12, 13, 14, 22, 23, 24, 32, 33, 34));
                chk("last_done", {71'd0, bus.FrameDone}, 72'd1);
            end
        end
        chk("frame_valid_count", 72'(validCnt), 72'd6);
        step(1'b0, 1'b0, 8'h00);
        chk("done_pulse_width", {71'd0, bus.FrameDone}, 72'd0);

        // Stall for three cycles after P(2,3).
        step(1'b1, 1'b0, 8'h00);
        for (int p = 0; p <= 13; p++) pix(p / IMG_W, p % IMG_W, 0);
        chk("pre_stall_valid", {71'd0, bus.WindowValid}, 72'd1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b0, 8'hAA);
            chk("stall_valid", {71'd0, bus.WindowValid}, 72'd0);
            chk("stall_window", bus.Window, lit(1, 2, 3, 11, 12, 13, 21, 22, 23));
        end
        pix(2, 4, 0);
        chk("resume_valid", {71'd0, bus.WindowValid}, 72'd1);
        chk("resume_window", bus.Window, lit(2, 3, 4, 12, 13, 14, 22, 23, 24));

        // Reset mid-frame after 7 pixels, then restream.
        step(1'b1, 1'b0, 8'h00);
        for (int p = 0; p < 7; p++) pix(p / IMG_W, p % IMG_W, 50);
        step(1'b1, 1'b0, 8'h00);
        chk("midrst_window", bus.Window, '0);
        chk("midrst_valid", {71'd0, bus.WindowValid}, 72'd0);
        chk("midrst_done",  {71'd0, bus.FrameDone},   72'd0);
        validCnt = 0;
        for (int p = 0; p < 13; p++) begin
            pix(p / IMG_W, p % IMG_W, 0);
            if (p < 12 && bus.WindowValid) validCnt++;
        end
        chk("midrst_early_valids", 72'(validCnt), 72'd0);
        chk("midrst_first_valid", {71'd0, bus.WindowValid}, 72'd1);
        chk("midrst_first_window", bus.Window, lit(0, 1, 2, 10, 11, 12, 20, 21, 22));

        // Reset and Enable together: pixel must not be accepted.
        step(1'b1, 1'b1, 8'h55);
        chk("rst_en_window", bus.Window, '0);
        chk("rst_en_valid", {71'd0, bus.WindowValid}, 72'd0);
        step(1'b1, 1'b1, 8'h66);
        validCnt = 0;
        for (int p = 0; p < 13; p++) begin
            pix(p / IMG_W, p % IMG_W, 0);
            if (p < 12 && bus.WindowValid) validCnt++;
        end
        chk("rst_en_early_valids", 72'(validCnt), 72'd0);
        chk("rst_en_first_valid", {71'd0, bus.WindowValid}, 72'd1);
        chk("rst_en_first_window", bus.Window, lit(0, 1, 2, 10, 11, 12, 20, 21, 22));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
